// File: rtl/shift_rotate_seq_if.sv
// Start/done handshake and operand/result bus for the shift/rotate sequencer.
interface shift_rotate_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] num_shifts;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             zero;

   modport master (
      output start, op, in, num_shifts,
      input  ready, busy, done, out, zero
   );

   modport slave (
      input  start, op, in, num_shifts,
      output ready, busy, done, out, zero
   );
endinterface

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate unit: ROR/ROL/SHR/SHL/SHRA, up to STEP bit positions per clock.
//  state | meaning
//  IDLE  | ready for a new request; out/zero hold the last result
//  SHIFT | working register advancing by min(count, STEP) per cycle
//  DONE  | one-cycle done pulse; out/zero freshly loaded
module shift_rotate_seq #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             clr,
   shift_rotate_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
   localparam logic [CW-1:0]    WIDTH_CW = CW'(WIDTH);
   localparam logic [CW-1:0]    STEP_CW  = CW'(STEP);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             zero_q, zero_d;

   logic [CW-1:0]    amt;
   logic [CW-1:0]    k;
   logic [WIDTH-1:0] shifted;

   // Effective amount: rotates wrap modulo WIDTH, shifts saturate at WIDTH.
   always_comb begin
      amt = '0;
      case (bus.op)
         3'b000, 3'b001:         amt = CW'(bus.num_shifts % WIDTH_V);
         3'b010, 3'b011, 3'b100: amt = (bus.num_shifts >= WIDTH_V) ? WIDTH_CW
                                                                  : CW'(bus.num_shifts);
         default:                amt = '0;
      endcase
   end

   always_comb begin
      k = (cnt_q > STEP_CW) ? STEP_CW : cnt_q;
      shifted = work_q;
      case (op_q)
         3'b000:  shifted = (work_q >> k) | (work_q << (WIDTH_CW - k));
         3'b001:  shifted = (work_q << k) | (work_q >> (WIDTH_CW - k));
         3'b010:  shifted = work_q >> k;
         3'b011:  shifted = work_q << k;
         3'b100:  shifted = $unsigned($signed(work_q) >>> k);
         default: shifted = work_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = done_q;
      out_d   = out_q;
      zero_d  = zero_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d    = bus.op;
               work_d  = bus.in;
               cnt_d   = amt;
               ready_d = 1'b0;
               if (amt != '0) begin
                  state_d = S_SHIFT;
                  busy_d  = 1'b1;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  out_d   = bus.in;
                  zero_d  = (bus.in == '0);
               end
            end
         end
         S_SHIFT: begin
            work_d = shifted;
            cnt_d  = cnt_q - k;
            if (cnt_q == k) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               out_d   = shifted;
               zero_d  = (shifted == '0);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.out   = out_q;
   assign bus.zero  = zero_q;
endmodule
